// File: rtl/ins_encoder.sv
// Instruction encoder: accepts one decoded instruction (icode, ifun, rA, rB,
// Val_C), validates it, and streams its byte encoding one byte per cycle into
// instruction memory starting at the current write pointer Val_P.
module ins_encoder #(
    parameter int MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adr_load,
    input  logic [63:0] start_adr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  Ins_Code,
    input  logic [3:0]  Ins_fun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] Val_C,
    output logic        mem_wr_en,
    output logic [63:0] mem_wr_adr,
    output logic [7:0]  mem_wr_data,
    output logic [63:0] Val_P,
    output logic        done,
    output logic        instruction_invalid_check,
    output logic        mem_invalid_check
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [3:0]  len;
    logic [3:0]  lat_icode;
    logic [3:0]  lat_ifun;
    logic [3:0]  lat_ra;
    logic [3:0]  lat_rb;
    logic [63:0] lat_valc;
    logic [63:0] base;
    logic        accept;

    // Encoded length in bytes for a given icode.
    function automatic logic [3:0] ins_len(input logic [3:0] icode);
        case (icode)
            4'h2, 4'h6, 4'hA, 4'hB: ins_len = 4'd2;
            4'h7, 4'h8:             ins_len = 4'd9;
            4'h3, 4'h4, 4'h5:       ins_len = 4'd10;
            default:                ins_len = 4'd1;
        endcase
    endfunction

    // Unknown icode or an ifun outside the range that icode defines.
    function automatic logic ins_bad(input logic [3:0] icode, input logic [3:0] ifun);
        if (icode > 4'hB) begin
            ins_bad = 1'b1;
        end else begin
            case (icode)
                4'h2, 4'h7: ins_bad = (ifun > 4'd6);
                4'h6:       ins_bad = (ifun > 4'd3);
                default:    ins_bad = (ifun != 4'd0);
            endcase
        end
    endfunction

    // Instructions that carry the rA/rB byte.
    function automatic logic has_regs(input logic [3:0] icode);
        case (icode)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regs = 1'b1;
            default:                                 has_regs = 1'b0;
        endcase
    endfunction

    // Byte k of the encoding; Val_C follows the header (and register byte if any).
    function automatic logic [7:0] ins_byte(input logic [3:0]  icode,
                                            input logic [3:0]  ifun,
                                            input logic [3:0]  ra,
                                            input logic [3:0]  rb,
                                            input logic [63:0] valc,
                                            input logic [3:0]  k);
        logic [3:0] off;
        logic [2:0] cidx;
        off  = has_regs(icode) ? 4'd2 : 4'd1;
        cidx = 3'(k - off);
        if (k == 4'd0) begin
            ins_byte = {icode, ifun};
        end else if (has_regs(icode) && k == 4'd1) begin
            ins_byte = {ra, rb};
        end else begin
            ins_byte = valc[{cidx, 3'b000} +: 8];
        end
    endfunction

    assign in_ready = (state == IDLE) && !adr_load;
    assign accept   = in_valid && in_ready;

    // Capture the instruction fields and start pointer at acceptance; held during EMIT.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_icode <= Ins_Code;
            lat_ifun  <= Ins_fun;
            lat_ra    <= rA;
            lat_rb    <= rB;
            lat_valc  <= Val_C;
            base      <= Val_P;
        end
    end

    // Control FSM with registered write port; byte 0 is presented on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                     <= IDLE;
            idx                       <= 4'd0;
            len                       <= 4'd0;
            Val_P                     <= 64'd0;
            mem_wr_en                 <= 1'b0;
            mem_wr_adr                <= 64'd0;
            mem_wr_data               <= 8'd0;
            done                      <= 1'b0;
            instruction_invalid_check <= 1'b0;
            mem_invalid_check         <= 1'b0;
        end else begin
            instruction_invalid_check <= 1'b0;
            mem_invalid_check         <= 1'b0;
            case (state)
                IDLE: begin
                    mem_wr_en   <= 1'b0;
                    mem_wr_adr  <= 64'd0;
                    mem_wr_data <= 8'd0;
                    done        <= 1'b0;
                    if (adr_load) begin
                        Val_P <= start_adr;
                    end else if (in_valid) begin
                        if (ins_bad(Ins_Code, Ins_fun)) begin
                            instruction_invalid_check <= 1'b1;
                        end else if (({1'b0, Val_P} + 65'(ins_len(Ins_Code))) > 65'(MEM_SIZE)) begin
                            mem_invalid_check <= 1'b1;
                        end else begin
                            state       <= EMIT;
                            len         <= ins_len(Ins_Code);
                            idx         <= 4'd1;
                            mem_wr_en   <= 1'b1;
                            mem_wr_adr  <= Val_P;
                            mem_wr_data <= {Ins_Code, Ins_fun};
                            done        <= (ins_len(Ins_Code) == 4'd1);
                        end
                    end
                end
                EMIT: begin
                    // The byte on the port this cycle is written at this edge.
                    Val_P <= Val_P + 64'd1;
                    if (idx == len) begin
                        state       <= IDLE;
                        idx         <= 4'd0;
                        mem_wr_en   <= 1'b0;
                        mem_wr_adr  <= 64'd0;
                        mem_wr_data <= 8'd0;
                        done        <= 1'b0;
                    end else begin
                        idx         <= idx + 4'd1;
                        mem_wr_adr  <= base + 64'(idx);
                        mem_wr_data <= ins_byte(lat_icode, lat_ifun, lat_ra, lat_rb, lat_valc, idx);
                        done        <= ((idx + 4'd1) == len);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_encoder.sv
// Self-checking bench for ins_encoder: directed scenarios plus randomized
// instructions checked against a byte-list reference model.
`timescale 1ns/1ps
module tb_ins_encoder;

    localparam int MEM_SIZE = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        adr_load = 1'b0;
    logic [63:0] start_adr = 64'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  Ins_Code = 4'd0;
    logic [3:0]  Ins_fun = 4'd0;
    logic [3:0]  rA = 4'd0;
    logic [3:0]  rB = 4'd0;
    logic [63:0] Val_C = 64'd0;
    logic        mem_wr_en;
    logic [63:0] mem_wr_adr;
    logic [7:0]  mem_wr_data;
    logic [63:0] Val_P;
    logic        done;
    logic        instruction_invalid_check;
    logic        mem_invalid_check;

    ins_encoder #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .adr_load(adr_load), .start_adr(start_adr),
        .in_valid(in_valid), .in_ready(in_ready), .Ins_Code(Ins_Code),
        .Ins_fun(Ins_fun), .rA(rA), .rB(rB), .Val_C(Val_C),
        .mem_wr_en(mem_wr_en), .mem_wr_adr(mem_wr_adr), .mem_wr_data(mem_wr_data),
        .Val_P(Val_P), .done(done),
        .instruction_invalid_check(instruction_invalid_check),
        .mem_invalid_check(mem_invalid_check)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] adr;
        logic [7:0]  data;
        logic        dn;
    } wr_t;

    wr_t         obs[$];
    int          inv_cnt = 0;
    int          mem_cnt = 0;
    logic [63:0] exp_valp = 64'd0;

    // Monitor: collect writes, count rejection pulses, check idle bus and ready-after-done.
    initial begin
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_wr_en) obs.push_back('{mem_wr_adr, mem_wr_data, done});
            else chk("bus_idle", {63'd0, |{mem_wr_adr, mem_wr_data, done}}, 64'd0);
            if (instruction_invalid_check) inv_cnt++;
            if (mem_invalid_check) mem_cnt++;
            if (prev_done) chk("ready_after_done", {63'd0, in_ready}, 64'd1);
            prev_done = done && mem_wr_en;
        end
    end

    // Reference model: the encoding as an explicit list of bytes.
    function automatic bit ref_ok(input logic [3:0] ic, input logic [3:0] fn);
        if (ic > 4'hB) return 1'b0;
        if (ic inside {4'h2, 4'h7}) return fn <= 4'd6;
        if (ic == 4'h6) return fn <= 4'd3;
        return fn == 4'd0;
    endfunction

    task automatic ref_bytes(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                             input logic [3:0] rb, input logic [63:0] vc, output logic [7:0] q[$]);
        q = {};
        q.push_back({ic, fn});
        if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) q.push_back({ra, rb});
        if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8})
            for (int i = 0; i < 8; i++) q.push_back(vc[8*i +: 8]);
    endtask

    // Present one instruction and let it be accepted, then scramble the field inputs.
    task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (t >= 30) chk("ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        Ins_Code = ic; Ins_fun = fn; rA = ra; rB = rb; Val_C = vc; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        Ins_Code = 4'($urandom); Ins_fun = 4'($urandom); rA = 4'($urandom); rB = 4'($urandom);
        Val_C = {$urandom, $urandom};
    endtask

    // Full transaction with model comparison.
    task automatic run_ins(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [63:0] vc);
        logic [7:0]  q[$];
        logic [64:0] endp;
        bit          ok;
        bit          fits;
        ref_bytes(ic, fn, ra, rb, vc, q);
        ok   = ref_ok(ic, fn);
        endp = {1'b0, exp_valp} + 65'(q.size());
        fits = (endp <= 65'(MEM_SIZE));
        obs.delete();
        inv_cnt = 0;
        mem_cnt = 0;
        issue(ic, fn, ra, rb, vc);
        repeat (12) @(negedge clk);
        #1;
        chk("inv_pulses", 64'(inv_cnt), ok ? 64'd0 : 64'd1);
        chk("mem_pulses", 64'(mem_cnt), (ok && !fits) ? 64'd1 : 64'd0);
        if (ok && fits) begin
            chk("n_writes", 64'(obs.size()), 64'(q.size()));
            for (int i = 0; i < q.size() && i < obs.size(); i++) begin
                chk($sformatf("wr%0d_adr", i), obs[i].adr, exp_valp + 64'(i));
                chk($sformatf("wr%0d_data", i), 64'(obs[i].data), 64'(q[i]));
                chk($sformatf("wr%0d_done", i), 64'(obs[i].dn), (i == q.size() - 1) ? 64'd1 : 64'd0);
            end
            exp_valp = exp_valp + 64'(q.size());
        end else begin
            chk("n_writes_rejected", 64'(obs.size()), 64'd0);
        end
        chk("val_p", Val_P, exp_valp);
    endtask

    // Load the write pointer, optionally with a competing in_valid that must lose.
    task automatic load_ptr(input logic [63:0] a, input bit with_valid);
        obs.delete();
        @(posedge clk);
        #1;
        adr_load = 1'b1;
        start_adr = a;
        if (with_valid) begin
            Ins_Code = 4'h0; Ins_fun = 4'h0; in_valid = 1'b1;
        end
        @(negedge clk);
        chk("ready_during_load", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        adr_load = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("load_no_write", 64'(obs.size()), 64'd0);
        exp_valp = a;
        chk("load_val_p", Val_P, a);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, {63'd0, mem_wr_en}, 64'd0);
        chk({tag, "_adr"}, mem_wr_adr, 64'd0);
        chk({tag, "_data"}, 64'(mem_wr_data), 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_checks"}, {62'd0, instruction_invalid_check, mem_invalid_check}, 64'd0);
        chk({tag, "_val_p"}, Val_P, 64'd0);
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [7:0] irm[10];
        logic [7:0] q[$];
        logic [3:0] ic, fn;
        irm = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // halt at address 0
        run_ins(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
        chk("halt_val_p", Val_P, 64'd1);

        // irmovq, checked against literal bytes as well as the model
        run_ins(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF);
        for (int i = 0; i < 10 && i < obs.size(); i++)
            chk($sformatf("irmovq_lit%0d", i), 64'(obs[i].data), 64'(irm[i]));
        chk("irmovq_val_p", Val_P, 64'd11);

        // cmovle then jmp
        run_ins(4'h2, 4'h1, 4'h2, 4'h3, 64'd0);
        run_ins(4'h7, 4'h0, 4'h0, 4'h0, 64'h40);

        // invalid icode and invalid OPq ifun
        run_ins(4'hC, 4'h0, 4'h0, 4'h0, 64'd0);
        run_ins(4'h6, 4'h5, 4'h1, 4'h2, 64'd0);

        // adr_load beats in_valid
        load_ptr(64'd100, 1'b1);

        // memory bound: irmovq rejected at 1020, nop fits
        load_ptr(64'd1020, 1'b0);
        run_ins(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF);
        run_ins(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
        chk("nop_val_p", Val_P, 64'd1021);

        // pointer near 2^64 must not wrap into range
        load_ptr(64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_ins(4'h9, 4'h0, 4'h0, 4'h0, 64'd0);

        // reset in the 4th EMIT cycle of an irmovq
        load_ptr(64'd0, 1'b0);
        ref_bytes(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, q);
        obs.delete();
        issue(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_n_writes", 64'(obs.size()), 64'd3);
        for (int i = 0; i < 3 && i < obs.size(); i++)
            chk($sformatf("abort_wr%0d_data", i), 64'(obs[i].data), 64'(q[i]));
        chk_reset_outputs("abort");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_valp = 64'd0;

        // randomized instructions with occasional pointer reloads
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0: load_ptr(64'($urandom_range(1010, 1024)), 1'b0);
                    1: load_ptr(64'($urandom_range(0, 200)), 1'b0);
                    default: load_ptr({32'hFFFF_FFFF, 32'($urandom_range(32'hFFFF_FFF0, 32'hFFFF_FFFF))}, 1'b0);
                endcase
            end
            ic = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) begin
                if (ic inside {4'h2, 4'h7}) fn = 4'($urandom_range(0, 6));
                else if (ic == 4'h6) fn = 4'($urandom_range(0, 3));
                else fn = 4'h0;
            end else begin
                fn = 4'($urandom_range(0, 15));
            end
            run_ins(ic, fn, 4'($urandom), 4'($urandom), {$urandom, $urandom});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
